// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle sequencer and the 64-bit RISC-V datapath.
// master: the sequencer. It samples instruction and alu_zero and drives every control flag.
// slave : the datapath. It drives instruction and alu_zero and consumes the flags.
// Signal names match the legacy port list so existing datapath wiring carries over unchanged.
interface multicycle_control_if;
  logic [31:0] instruction;
  logic        alu_zero;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        PCSource;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUOp;
  logic        LoadAOut;
  logic        RegWrite;
  logic        LoadRegA;
  logic        LoadRegB;
  logic        MemToReg;
  logic        DMemOp;
  logic        LoadMDR;
  logic        IMemRead;
  logic        IRWrite;
  logic        halted;
  logic        retire;

  modport master (
    input  instruction, alu_zero,
    output PCWrite, PCWriteCond, PCSource, ALUSrcA, ALUSrcB, ALUOp,
           LoadAOut, RegWrite, LoadRegA, LoadRegB, MemToReg, DMemOp,
           LoadMDR, IMemRead, IRWrite, halted, retire
  );

  modport slave (
    output instruction, alu_zero,
    input  PCWrite, PCWriteCond, PCSource, ALUSrcA, ALUSrcB, ALUOp,
           LoadAOut, RegWrite, LoadRegA, LoadRegB, MemToReg, DMemOp,
           LoadMDR, IMemRead, IRWrite, halted, retire
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle RV64 datapath. It decodes the IR word in DECODE,
// walks a per-class state sequence and resolves beq/bne from alu_zero. Unsupported
// encodings park the sequencer in HALT until reset.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high. It forces every output to 0 while it is high.
//   bus   - multicycle_control_if.master. It carries instruction and alu_zero in, and all control flags out.
module multicycle_control (
  input  logic                       clk,
  input  logic                       reset,
  multicycle_control_if.master       bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_IR_LOAD, S_DECODE, S_EX_R, S_WB_R, S_EX_I, S_WB_I,
    S_MEM_ADDR, S_LD_READ, S_LD_WB, S_SD_WRITE, S_LUI_WB, S_BRANCH,
    S_PC_INC, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_PASS_B = 3'b000,
    OP_ADD    = 3'b001,
    OP_SUB    = 3'b010,
    OP_AND    = 3'b011,
    OP_OR     = 3'b100
  } alu_op_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
    logic       load_aout;
    logic       reg_write;
    logic       load_reg_a;
    logic       load_reg_b;
    logic       mem_to_reg;
    logic       dmem_op;
    logic       load_mdr;
    logic       imem_read;
    logic       ir_write;
    logic       halted;
    logic       retire;
  } ctrl_t;

  // Control word for a state. In BRANCH the taken-path strobes are set here and
  // are qualified by alu_zero at the output.
  function automatic ctrl_t ctrl_of(input state_t s, input alu_op_t rop);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   c.imem_read = 1'b1;
      S_IR_LOAD: begin
        c.imem_read = 1'b1;
        c.ir_write  = 1'b1;
      end
      S_DECODE: begin
        c.load_reg_a = 1'b1;
        c.load_reg_b = 1'b1;
        c.alu_src_b  = 2'b11;
        c.alu_op     = OP_ADD;
        c.load_aout  = 1'b1;
      end
      S_EX_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = rop;
        c.load_aout = 1'b1;
      end
      S_WB_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = rop;
        c.reg_write = 1'b1;
      end
      S_EX_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = OP_ADD;
        c.load_aout = 1'b1;
      end
      S_WB_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = OP_ADD;
        c.reg_write = 1'b1;
      end
      S_MEM_ADDR, S_LD_READ, S_SD_WRITE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = OP_ADD;
        c.load_mdr  = (s == S_LD_READ);
        c.dmem_op   = (s == S_SD_WRITE);
      end
      S_LD_WB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_LUI_WB: begin
        c.alu_src_b = 2'b10;
        c.alu_op    = OP_PASS_B;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = OP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_write      = 1'b1;
        c.pc_source     = 1'b1;
        c.retire        = 1'b1;
      end
      S_PC_INC: begin
        c.alu_src_b = 2'b01;
        c.alu_op    = OP_ADD;
        c.pc_write  = 1'b1;
        c.retire    = 1'b1;
      end
      S_HALT:   c.halted = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_t  state, nxt;
  alu_op_t r_op_q, r_op_d;
  logic    store_q, store_d;
  ctrl_t   ctrl_q, out_c;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       taken;
  logic       unused_fields;

  assign opcode        = bus.instruction[6:0];
  assign funct3        = bus.instruction[14:12];
  assign funct7        = bus.instruction[31:25];
  assign unused_fields = ^{bus.instruction[24:15], bus.instruction[11:7]};
  assign taken         = funct3[0] ? ~bus.alu_zero : bus.alu_zero;

  state_t  dec_state;
  alu_op_t dec_op;
  logic    dec_store;

  always_comb begin
    dec_state = S_HALT;
    dec_op    = OP_ADD;
    dec_store = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  begin dec_state = S_EX_R; dec_op = OP_ADD; end
            3'b110:  begin dec_state = S_EX_R; dec_op = OP_OR;  end
            3'b111:  begin dec_state = S_EX_R; dec_op = OP_AND; end
            default: dec_state = S_HALT;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_state = S_EX_R;
          dec_op    = OP_SUB;
        end
      end
      7'b0010011: if (funct3 == 3'b000) dec_state = S_EX_I;
      7'b0000011: if (funct3 == 3'b011) dec_state = S_MEM_ADDR;
      7'b0100011: if (funct3 == 3'b011) begin
        dec_state = S_MEM_ADDR;
        dec_store = 1'b1;
      end
      7'b1100011: if (funct3 == 3'b000 || funct3 == 3'b001) dec_state = S_BRANCH;
      7'b0110111: dec_state = S_LUI_WB;
      default:    dec_state = S_HALT;
    endcase
  end

  // The R-type ALU op and the ld/sd choice are latched in DECODE. Because of this,
  // EX->WB and MEM_ADDR->LD_READ/SD_WRITE keep the same ALU controls without re-reading the IR.
  always_comb begin
    nxt     = state;
    r_op_d  = r_op_q;
    store_d = store_q;
    case (state)
      S_FETCH:    nxt = S_IR_LOAD;
      S_IR_LOAD:  nxt = S_DECODE;
      S_DECODE: begin
        nxt     = dec_state;
        r_op_d  = dec_op;
        store_d = dec_store;
      end
      S_EX_R:     nxt = S_WB_R;
      S_WB_R:     nxt = S_PC_INC;
      S_EX_I:     nxt = S_WB_I;
      S_WB_I:     nxt = S_PC_INC;
      S_MEM_ADDR: nxt = store_q ? S_SD_WRITE : S_LD_READ;
      S_LD_READ:  nxt = S_LD_WB;
      S_LD_WB:    nxt = S_PC_INC;
      S_SD_WRITE: nxt = S_PC_INC;
      S_LUI_WB:   nxt = S_PC_INC;
      S_BRANCH:   nxt = taken ? S_FETCH : S_PC_INC;
      S_PC_INC:   nxt = S_FETCH;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_HALT;
    endcase
  end

  // The registered control word is decoded from the state being entered, so
  // the outputs change together with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      r_op_q  <= OP_ADD;
      store_q <= 1'b0;
      ctrl_q  <= ctrl_of(S_FETCH, OP_ADD);
    end else begin
      state   <= nxt;
      r_op_q  <= r_op_d;
      store_q <= store_d;
      ctrl_q  <= ctrl_of(nxt, r_op_d);
    end
  end

  always_comb begin
    out_c = ctrl_q;
    if (state == S_BRANCH && !taken) begin
      out_c.pc_write  = 1'b0;
      out_c.pc_source = 1'b0;
      out_c.retire    = 1'b0;
    end
    if (reset) out_c = '0;
  end

  assign bus.PCWrite     = out_c.pc_write;
  assign bus.PCWriteCond = out_c.pc_write_cond;
  assign bus.PCSource    = out_c.pc_source;
  assign bus.ALUSrcA     = out_c.alu_src_a;
  assign bus.ALUSrcB     = out_c.alu_src_b;
  assign bus.ALUOp       = out_c.alu_op;
  assign bus.LoadAOut    = out_c.load_aout;
  assign bus.RegWrite    = out_c.reg_write;
  assign bus.LoadRegA    = out_c.load_reg_a;
  assign bus.LoadRegB    = out_c.load_reg_b;
  assign bus.MemToReg    = out_c.mem_to_reg;
  assign bus.DMemOp      = out_c.dmem_op;
  assign bus.LoadMDR     = out_c.load_mdr;
  assign bus.IMemRead    = out_c.imem_read;
  assign bus.IRWrite     = out_c.ir_write;
  assign bus.halted      = out_c.halted;
  assign bus.retire      = out_c.retire;

endmodule
